// File: rtl/conv_pkg.sv
// Shared types, default widths and the output rounding helper for conv_stream_engine.
// Optional: define CONV_SAT_EN to saturate results instead of wrapping them.
package conv_pkg;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int ACC_W     = 40;
  localparam int OUT_SHIFT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    OUT   = 2'd2,
    FLUSH = 2'd3
  } state_e;

  // Round half up, arithmetic shift, then saturate or wrap to DATA_W.
  function automatic logic [DATA_W-1:0] round_out(input logic signed [ACC_W-1:0] acc,
                                                  input int unsigned shift);
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;
`ifdef CONV_SAT_EN
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
`endif
    sum     = (ACC_W+1)'(acc) + ((ACC_W+1)'(1) << (shift - 1));
    shifted = sum >>> shift;
`ifdef CONV_SAT_EN
    hi = (ACC_W+1)'((longint'(1) << (DATA_W - 1)) - 1);
    lo = ~hi;
    if (shifted > hi) return hi[DATA_W-1:0];
    if (shifted < lo) return lo[DATA_W-1:0];
`endif
    return shifted[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Serial signed multiply-accumulate; result is the accumulator value after this enable.
module conv_mac #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int COEF_W = conv_pkg::COEF_W,
  parameter int ACC_W  = conv_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  result
);

  logic signed [DATA_W+COEF_W-1:0] product;
  logic signed [ACC_W-1:0]         acc_q;

  assign product = sample * coef;
  assign result  = acc_q + ACC_W'(product);

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= result;
    end
  end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming full-convolution FIR: sample-in, TAPS-cycle serial MAC, registered
// result-out, then TAPS-1 zero-fed flush steps. CONV_SAT_EN selects saturation.
module conv_stream_engine #(
  parameter int TAPS      = 20,
  parameter int DATA_W    = conv_pkg::DATA_W,
  parameter int COEF_W    = conv_pkg::COEF_W,
  parameter int ACC_W     = conv_pkg::ACC_W,
  parameter int OUT_SHIFT = conv_pkg::OUT_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_idx,
  input  logic [COEF_W-1:0]        coef_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam logic [1:0] S_IDLE  = conv_pkg::IDLE;
  localparam logic [1:0] S_MAC   = conv_pkg::MAC;
  localparam logic [1:0] S_OUT   = conv_pkg::OUT;
  localparam logic [1:0] S_FLUSH = conv_pkg::FLUSH;

  localparam int              CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(TAPS - 1);

  logic [1:0]               state;
  logic [CNT_W-1:0]         k_q;
  logic [CNT_W-1:0]         flush_cnt;
  logic                     last_q;
  logic                     alive_q;
  logic signed [DATA_W-1:0] dline  [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [ACC_W-1:0]  mac_result;
  logic                     accept;
  logic                     last_done;

  // alive_q keeps in_ready low until the first clock edge after reset release.
  assign in_ready  = alive_q && (state == S_IDLE) && !coef_we;
  assign accept    = in_valid && in_ready;
  assign last_done = (state == S_OUT) && out_ready && out_last;

  conv_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept || (state == S_FLUSH)),
    .en     (state == S_MAC),
    .sample (dline[k_q]),
    .coef   (coef_q[k_q]),
    .result (mac_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k_q       <= '0;
      flush_cnt <= '0;
      last_q    <= 1'b0;
      alive_q   <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state  <= S_MAC;
            k_q    <= '0;
            last_q <= in_last;
            busy   <= 1'b1;
          end
        end
        S_MAC: begin
          // The final product is folded straight into the output register.
          if (k_q == K_LAST) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
            out_data  <= conv_pkg::round_out(mac_result, OUT_SHIFT);
            out_last  <= last_q && (flush_cnt == K_LAST);
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state     <= S_IDLE;
              last_q    <= 1'b0;
              flush_cnt <= '0;
              busy      <= 1'b0;
            end else if (last_q) begin
              state <= S_FLUSH;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state     <= S_MAC;
          k_q       <= '0;
          flush_cnt <= flush_cnt + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) dline[i] <= '0;
    end else if (last_done) begin
      for (int i = 0; i < TAPS; i++) dline[i] <= '0;
    end else if (accept || (state == S_FLUSH)) begin
      dline[0] <= accept ? in_data : '0;
      for (int i = 1; i < TAPS; i++) dline[i] <= dline[i-1];
    end
  end

  // NOTE: the coefficient file is a register array with an explicit reset, so
  // a reset really clears h[] rather than leaving stale taps from the last run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else if ((state == S_IDLE) && coef_we && (int'(coef_idx) < TAPS)) begin
      coef_q[coef_idx] <= coef_data;
    end
  end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench for conv_stream_engine: a reference convolution pushes expected
// outputs, a negedge monitor pops and compares on every output transfer.
module tb_conv_stream_engine;

  localparam int TAPS = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        coef_we = 1'b0;
  logic [4:0]  coef_idx = '0;
  logic [15:0] coef_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   hm[TAPS];
  int   xs[$];
  int   checks = 0;
  int   errors = 0;

  conv_stream_engine #(.TAPS(TAPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coef_we   (coef_we),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout_%s: event did not occur within its cycle budget", name);
  endtask

  // Monitor: every output transfer is compared with the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h expected no output", out_data);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 64'(out_data), 64'(mon_e.data));
        check("out_last", 64'(out_last), 64'(mon_e.last));
      end
    end
  end

  // Reference full convolution with round-half-up and the configured reduction.
  task automatic push_expected();
    int n = xs.size();
    for (int j = 0; j < n + TAPS - 1; j++) begin
      longint acc;
      longint r;
      exp_t   e;
      acc = 0;
      for (int k = 0; k < TAPS; k++)
        if (j - k >= 0 && j - k < n) acc += longint'(hm[k]) * longint'(xs[j-k]);
      r = (acc + 64'sd16384) >>> 15;
`ifdef CONV_SAT_EN
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
`endif
      e.data = r[15:0];
      e.last = (j == n + TAPS - 2);
      sb.push_back(e);
    end
  endtask

  task automatic write_coef(input int idx, input logic [15:0] val, input logic with_sample);
    @(posedge clk);
    #1;
    coef_we   = 1'b1;
    coef_idx  = 5'(idx);
    coef_data = val;
    in_valid  = with_sample;
    in_data   = 16'h5A5A;
    @(negedge clk);
    check("in_ready_during_coef_we", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    coef_we  = 1'b0;
    in_valid = 1'b0;
    hm[idx]  = int'($signed(val));
  endtask

  task automatic send_sample(input logic [15:0] d, input logic last);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      if (got) break;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!got) timeout("accept");
  endtask

  task automatic send_signal();
    push_expected();
    for (int i = 0; i < xs.size(); i++) send_sample(xs[i][15:0], i == xs.size() - 1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      timeout(name);
      sb.delete();
    end
    @(posedge clk);
    #1;
    check({name, "_busy_low"}, 64'(busy), 64'd0);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Pass-through gain, with backpressure on the first output.
    write_coef(0, 16'h4000, 1'b1);
    check("coef_beats_sample_busy", 64'(busy), 64'd0);
    for (int k = 1; k < TAPS; k++) write_coef(k, 16'h0000, 1'b0);
    out_ready = 1'b0;
    xs = '{32'h2000};
    send_signal();
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) timeout("bp_out_valid");
    end
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data", 64'(out_data), 64'h1000);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_transfer_done", 64'(out_valid), 64'd0);
    wait_drain("pass", 2000);

    // Impulse response: outputs reproduce h[k].
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'(k * 256), 1'b0);
    xs = '{32'h7FFF};
    send_signal();
    wait_drain("impulse", 2000);

    // Saturation / wrap of the second output.
    write_coef(0, 16'h7FFF, 1'b0);
    write_coef(1, 16'h7FFF, 1'b0);
    for (int k = 2; k < TAPS; k++) write_coef(k, 16'h0000, 1'b0);
    xs = '{32'h7FFF, 32'h7FFF};
    send_signal();
    wait_drain("sat", 2000);

    // Length check with random coefficients and 2401 samples.
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'($urandom_range(0, 65535)), 1'b0);
    xs.delete();
    for (int i = 0; i < 2401; i++) xs.push_back(int'($signed(16'($urandom_range(0, 65535)))));
    send_signal();
    wait_drain("length", 4000);

    // Reset three cycles into MAC, then a fresh run with cleared coefficients.
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'h4000, 1'b0);
    send_sample(16'h1000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midmac_out_valid", 64'(out_valid), 64'd0);
    check("midmac_out_data", 64'(out_data), 64'd0);
    check("midmac_out_last", 64'(out_last), 64'd0);
    check("midmac_busy", 64'(busy), 64'd0);
    check("midmac_in_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < TAPS; k++) hm[k] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midmac_post_rst_in_ready", 64'(in_ready), 64'd1);
    xs = '{32'h1234};
    send_signal();
    wait_drain("after_reset", 2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_stream_engine.md
# conv_stream_engine

Streaming FIR convolution engine: the responder behind the convolution bench's handshake, replacing flattened-bus transfer with per-sample streaming. It accepts a signal sample by sample, convolves it with a loaded TAPS-long Q15 coefficient set using one serial multiply-accumulate, and emits all N+TAPS-1 full-convolution outputs. The output stream is marked with a last flag, and an idle/busy status serves as the completion indicator.

## Interface
- TAPS, 20, filter length (coefficient count)
- DATA_W, 16, signed sample and output width
- COEF_W, 16, signed coefficient width (Q15)
- ACC_W, 40, signed accumulator width
- OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before output
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- coef_we  input  1  coefficient write strobe, honoured only in IDLE
- coef_idx  input  $clog2(TAPS)  coefficient index k
- coef_data  input  COEF_W  value h[k]
- in_valid  input  1  sample offered
- in_ready  output  1  engine accepts a sample this cycle
- in_data  input  DATA_W  sample x[n]
- in_last  input  1  final sample of the signal
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_data  output  DATA_W  y[n] = sum over k of h[k]*x[n-k]
- out_last  output  1  final output, index N+TAPS-2
- busy  output  1  high from the first accepted sample until the out_last transfer completes

## Operation
- States: IDLE, MAC, OUT, FLUSH.
- IDLE:
  - in_ready=1 when coef_we=0.
  - A write with coef_we=1 stores h[coef_idx] and forces in_ready=0 that cycle.
- Sample accept (in_valid & in_ready):
  - The delay line shifts, with x[n] entering at position 0.
  - in_last is latched, then the state moves to MAC.
- MAC:
  - One product per cycle over TAPS cycles, k=0..TAPS-1.
  - The accumulator is cleared at MAC entry.
  - Products are sign-extended to ACC_W.
- OUT:
  - Output value = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (round half up), reduced to DATA_W per Configuration.
  - out_valid is held with a stable out_data until out_ready.
  - On transfer, the state goes to IDLE, or to FLUSH if last was latched or a flush is in progress.
- FLUSH:
  - Shifts a zero into the delay line internally, with no input handshake, then goes to MAC.
  - Repeats TAPS-1 times.
  - out_last is asserted on the output of the final flush step.
- After the out_last transfer: clear the delay line, the last latch and the flush counter, then return to IDLE.
- Coefficients persist across signals.
- in_last with TAPS=1 produces no flush; out_last is asserted on that sample's output.
- A coef_we outside IDLE is ignored.
- Same-cycle coef_we and in_valid in IDLE: the coefficient write wins and the sample is not accepted.

## Timing
- Reset values:
  - in_ready=0 during reset, 1 on the first cycle after release.
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - Delay line, accumulator and coefficients all 0; state IDLE.
- Latency: accepted sample to out_valid is TAPS+1 cycles.
- Throughput with out_ready held high: one output per TAPS+2 cycles.
- Flush steps take the same TAPS+2 cycles each.
- out_valid and out_data are registered outputs.
- Reset asserted mid-MAC or mid-OUT aborts the operation and takes the reset values at once. A pending output is discarded.

## Configuration
- CONV_SAT_EN defined: the rounded, shifted accumulator is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- CONV_SAT_EN undefined: the low DATA_W bits are taken (two's-complement wrap).

## Structure
- Package conv_pkg holds:
  - the state enum (IDLE, MAC, OUT, FLUSH)
  - default width constants DATA_W, COEF_W, ACC_W
  - the rounding and saturation function
- Sub-module conv_mac:
  - signed multiplier plus accumulator
  - clear/enable inputs and an ACC_W result
  - instantiated once
- The top level holds the FSM, delay line, coefficient register file and flush counter.

## Test plan
- Pass-through gain: h[0]=0x4000, others 0; feed x={0x2000} with last -> outputs 0x1000, then 19 zeros. out_last on output 20; busy falls after that transfer.
- Impulse response: h[k]=k*0x0100; feed a single x=0x7FFF with last -> 20 outputs equal to h[k] exactly, out_last on the 20th.
- Saturation: h[0]=h[1]=0x7FFF; feed x={0x7FFF,0x7FFF} -> second output 0x7FFF with CONV_SAT_EN, 0xFFFC without.
- Backpressure: hold out_ready=0 for 5 cycles while out_valid=1 -> out_data stable, in_ready=0 throughout. The transfer completes on the first cycle out_ready=1.
- Length check: load random coefficients and stream 2401 random samples -> exactly 2420 outputs matching a reference model, out_last only on the last.
- Reset mid-MAC: drop rst_n 3 cycles into MAC -> all outputs at reset values immediately. A fresh single-sample run afterwards yields all-zero outputs, because the coefficients were cleared.
